// File: rtl/counting_register_file.sv
// counting_register_file: multi-port register file with per-port signed
// pre/post count, tri-state read buses and a single synchronous write port.

module counting_rf_port #(
    parameter int WORD_SIZE   = 32,
    parameter int COUNT_WIDTH = 8
) (
    input  logic [WORD_SIZE-1:0]   rd_word,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic                   pre_count,
    input  logic                   post_count,
    output logic [WORD_SIZE-1:0]   delta,
    output logic                   cnt,
    output logic [WORD_SIZE-1:0]   rd_val
);
    always_comb begin
        delta                  = {WORD_SIZE{count[COUNT_WIDTH-1]}};
        delta[COUNT_WIDTH-1:0] = count;
    end

    // pre and post together behave as a single pre-count
    assign cnt    = pre_count | post_count;
    assign rd_val = pre_count ? rd_word + delta : rd_word;
endmodule

module counting_register_file #(
    parameter int WORD_SIZE   = 32,
    parameter int SEL_WIDTH   = 4,
    parameter int DEPTH       = 2**SEL_WIDTH,
    parameter int COUNT_WIDTH = 8,
    parameter int READ_PORTS  = 2,
    parameter int ZERO_REG    = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output tri   [READ_PORTS*WORD_SIZE-1:0]   out,
    input  logic [READ_PORTS-1:0]             oe,
    input  logic [READ_PORTS*SEL_WIDTH-1:0]   sel,
    input  logic [READ_PORTS*COUNT_WIDTH-1:0] count,
    input  logic [READ_PORTS-1:0]             pre_count,
    input  logic [READ_PORTS-1:0]             post_count,
    input  logic [WORD_SIZE-1:0]              in,
    input  logic                              ld,
    input  logic [SEL_WIDTH-1:0]              sel_in
);
    localparam int NSEL = 2**SEL_WIDTH;

    typedef struct packed {
        logic                 cnt;
        logic [SEL_WIDTH-1:0] sel;
        logic [WORD_SIZE-1:0] delta;
    } cnt_req_t;

    logic [READ_PORTS-1:0][SEL_WIDTH-1:0] sel_v;
    logic [READ_PORTS-1:0][WORD_SIZE-1:0] rd_word;
    logic [READ_PORTS-1:0][WORD_SIZE-1:0] rd_val;
    logic [READ_PORTS-1:0][WORD_SIZE-1:0] delta;
    logic [READ_PORTS-1:0]                cnt;
    cnt_req_t [READ_PORTS-1:0]            req;
    // full select space; unimplemented or hardwired entries read as zero
    logic [NSEL-1:0][WORD_SIZE-1:0]       rd_tab;

    assign sel_v = sel;

    counting_rf_port #(
        .WORD_SIZE  (WORD_SIZE),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_port [READ_PORTS-1:0] (
        .rd_word   (rd_word),
        .count     (count),
        .pre_count (pre_count),
        .post_count(post_count),
        .delta     (delta),
        .cnt       (cnt),
        .rd_val    (rd_val)
    );

    generate
        for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
            assign rd_word[p] = rd_tab[sel_v[p]];
            assign req[p]     = {cnt[p], sel_v[p], delta[p]};
            assign out[p*WORD_SIZE +: WORD_SIZE] = oe[p] ? rd_val[p] : 'z;
        end

        for (genvar r = 0; r < NSEL; r++) begin : g_reg
            if (r >= DEPTH || (ZERO_REG != 0 && r == 0)) begin : g_const
                assign rd_tab[r] = '0;
            end else begin : g_store
                logic [WORD_SIZE-1:0] q;
                logic [WORD_SIZE-1:0] sum;

                // every port counting on this register contributes its delta
                always_comb begin
                    sum = '0;
                    for (int p = 0; p < READ_PORTS; p++)
                        if (req[p].cnt && req[p].sel == SEL_WIDTH'(r))
                            sum = sum + req[p].delta;
                end

                always_ff @(posedge clk or negedge rst_n)
                    if (!rst_n)
                        q <= '0;
                    else if (ld && sel_in == SEL_WIDTH'(r))
                        q <= in;
                    else
                        q <= q + sum;

                assign rd_tab[r] = q;
            end
        end
    endgenerate
endmodule

// File: tb/tb_counting_register_file.sv
// Bench: two configurations (2-port full depth; 3-port, depth 12, zero reg)
// checked against an array model of the register contents.

module tb_counting_register_file;
    localparam int W = 32;
    localparam int NP    [2] = '{2, 3};
    localparam int DEPTH [2] = '{16, 12};
    localparam int ZR    [2] = '{0, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      t_oe   [2];
    logic [2:0]      t_pre  [2];
    logic [2:0]      t_post [2];
    logic [2:0][3:0] t_sel  [2];
    logic [2:0][7:0] t_cnt  [2];
    logic [W-1:0]    t_in   [2];
    logic            t_ld   [2];
    logic [3:0]      t_selin[2];

    tri [2*W-1:0] o0;
    tri [3*W-1:0] o1;
    for (genvar i = 0; i < 2*W; i++) begin : g_pu0
        pullup (o0[i]);
    end
    for (genvar i = 0; i < 3*W; i++) begin : g_pu1
        pullup (o1[i]);
    end

    logic [W-1:0] m [2][16];
    int n_vec = 0;
    int n_err = 0;

    counting_register_file u_dut0 (
        .clk(clk), .rst_n(rst_n), .out(o0),
        .oe(t_oe[0][1:0]), .sel(t_sel[0][1:0]), .count(t_cnt[0][1:0]),
        .pre_count(t_pre[0][1:0]), .post_count(t_post[0][1:0]),
        .in(t_in[0]), .ld(t_ld[0]), .sel_in(t_selin[0])
    );

    counting_register_file #(.READ_PORTS(3), .DEPTH(12), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .out(o1),
        .oe(t_oe[1]), .sel(t_sel[1]), .count(t_cnt[1]),
        .pre_count(t_pre[1]), .post_count(t_post[1]),
        .in(t_in[1]), .ld(t_ld[1]), .sel_in(t_selin[1])
    );

    function automatic logic [W-1:0] sext(logic [7:0] c);
        return {{24{c[7]}}, c};
    endfunction

    function automatic logic [W-1:0] mread(int d, logic [3:0] s);
        if (int'(s) >= DEPTH[d] || (ZR[d] == 1 && s == 4'd0)) return '0;
        return m[d][s];
    endfunction

    function automatic logic [W-1:0] expect_out(int d, int p);
        if (!t_oe[d][p]) return '1;
        return mread(d, t_sel[d][p]) + (t_pre[d][p] ? sext(t_cnt[d][p]) : W'(0));
    endfunction

    function automatic logic [W-1:0] bus(int d, int p);
        return (d == 0) ? o0[p*W +: W] : o1[p*W +: W];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 16; r++) m[d][r] = '0;
    endtask

    // counts accumulate first, then a load overwrites the target
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic [W-1:0] nxt [16];
            nxt = m[d];
            for (int p = 0; p < NP[d]; p++)
                if ((t_pre[d][p] || t_post[d][p]) && int'(t_sel[d][p]) < DEPTH[d])
                    nxt[t_sel[d][p]] = nxt[t_sel[d][p]] + sext(t_cnt[d][p]);
            if (t_ld[d] && int'(t_selin[d]) < DEPTH[d]) nxt[t_selin[d]] = t_in[d];
            if (ZR[d] == 1) nxt[0] = '0;
            m[d] = nxt;
        end
    endtask

    task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < NP[d]; p++)
                chk($sformatf("%s d%0d p%0d", tag, d, p), bus(d, p), expect_out(d, p));
    endtask

    task automatic tick();
        #1;
        check_all("cycle");
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic clear_in();
        for (int d = 0; d < 2; d++) begin
            t_oe[d] = '0; t_pre[d] = '0; t_post[d] = '0;
            t_sel[d] = '0; t_cnt[d] = '0;
            t_in[d] = '0; t_ld[d] = 1'b0; t_selin[d] = '0;
        end
    endtask

    task automatic setp(int d, int p, logic oe, logic [3:0] s, logic [7:0] c,
                        logic pre, logic post);
        t_oe[d][p] = oe; t_sel[d][p] = s; t_cnt[d][p] = c;
        t_pre[d][p] = pre; t_post[d][p] = post;
    endtask

    task automatic load(int d, logic [3:0] r, logic [W-1:0] v);
        clear_in();
        t_ld[d] = 1'b1; t_selin[d] = r; t_in[d] = v;
        tick();
        clear_in();
    endtask

    task automatic scan();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 16; r++) begin
                clear_in();
                setp(d, 0, 1'b1, 4'(r), 8'h00, 1'b0, 1'b0);
                #1;
                chk($sformatf("scan d%0d r%0d", d, r), bus(d, 0), mread(d, 4'(r)));
            end
    endtask

    initial begin
        clear_in();
        model_clear();

        // in reset: disabled ports float (pulled high), enabled ports read 0 (+delta)
        #2;
        check_all("reset z");
        setp(0, 0, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
        setp(0, 1, 1'b1, 4'd7, 8'h03, 1'b1, 1'b0);
        #1;
        chk("reset read", bus(0, 0), 32'h0);
        chk("reset pre", bus(0, 1), 32'h3);
        #9 rst_n = 1'b1;
        clear_in();
        tick();

        // async reset mid-cycle clears contents immediately
        load(0, 4'd3, 32'h1234);
        load(1, 4'd3, 32'h1234);
        setp(0, 0, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
        #1;
        chk("r3 loaded", bus(0, 0), 32'h1234);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("async clear", bus(0, 0), 32'h0);
        chk("oe off z", bus(0, 1), 32'hFFFF_FFFF);
        t_ld[0] = 1'b1; t_selin[0] = 4'd3; t_in[0] = 32'hDEAD;
        tick();
        rst_n = 1'b1;
        clear_in();
        scan();

        // post-count then pre-count
        load(0, 4'd2, 32'd100);
        setp(0, 0, 1'b1, 4'd2, 8'hFC, 1'b0, 1'b1);
        #1 chk("post old", bus(0, 0), 32'd100);
        tick();
        t_post[0][0] = 1'b0;
        #1 chk("post new", bus(0, 0), 32'd96);
        t_pre[0][0] = 1'b1; t_cnt[0][0] = 8'h08;
        #1 chk("pre same", bus(0, 0), 32'd104);
        tick();
        t_pre[0][0] = 1'b0;
        #1 chk("pre stored", bus(0, 0), 32'd104);

        // two ports counting the same register
        load(0, 4'd5, 32'h10);
        setp(0, 0, 1'b1, 4'd5, 8'h01, 1'b0, 1'b1);
        setp(0, 1, 1'b1, 4'd5, 8'h02, 1'b0, 1'b1);
        tick();
        clear_in();
        setp(0, 0, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
        #1 chk("dual sum", bus(0, 0), 32'h13);
        setp(0, 0, 1'b1, 4'd5, 8'h04, 1'b1, 1'b1);
        #1 chk("pre+post out", bus(0, 0), 32'h17);
        tick();
        clear_in();
        setp(0, 0, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
        #1 chk("pre+post once", bus(0, 0), 32'h17);

        // load beats a count on the same register
        load(0, 4'd1, 32'd7);
        setp(0, 0, 1'b1, 4'd1, 8'h01, 1'b0, 1'b1);
        t_ld[0] = 1'b1; t_selin[0] = 4'd1; t_in[0] = 32'h50;
        #1 chk("ld old read", bus(0, 0), 32'd7);
        tick();
        clear_in();
        setp(0, 0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0);
        #1 chk("ld wins", bus(0, 0), 32'h50);

        // wraparound both directions
        load(0, 4'd4, 32'hFFFF_FFFF);
        setp(0, 0, 1'b1, 4'd4, 8'h01, 1'b1, 1'b0);
        #1 chk("wrap pre", bus(0, 0), 32'h0);
        tick();
        setp(0, 0, 1'b1, 4'd4, 8'h00, 1'b0, 1'b0);
        #1 chk("wrap up", bus(0, 0), 32'h0);
        setp(0, 0, 1'b1, 4'd4, 8'hFF, 1'b0, 1'b1);
        tick();
        setp(0, 0, 1'b1, 4'd4, 8'h00, 1'b0, 1'b0);
        #1 chk("wrap down", bus(0, 0), 32'hFFFF_FFFF);

        // hardwired zero register, three ports, out-of-range select
        clear_in();
        setp(1, 0, 1'b1, 4'd0, 8'h05, 1'b0, 1'b1);
        t_ld[1] = 1'b1; t_selin[1] = 4'd0; t_in[1] = 32'hAA;
        tick();
        clear_in();
        setp(1, 0, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0);
        #1 chk("zero reg", bus(1, 0), 32'h0);
        setp(1, 0, 1'b1, 4'd0, 8'h05, 1'b1, 1'b0);
        #1 chk("zero pre", bus(1, 0), 32'h5);
        load(1, 4'd7, 32'h77);
        load(1, 4'd9, 32'h99);
        setp(1, 0, 1'b1, 4'd7, 8'h00, 1'b0, 1'b0);
        setp(1, 1, 1'b1, 4'd9, 8'h00, 1'b0, 1'b0);
        #1;
        chk("3p port0", bus(1, 0), 32'h77);
        chk("3p port1", bus(1, 1), 32'h99);
        chk("3p port2 z", bus(1, 2), 32'hFFFF_FFFF);
        load(1, 4'd13, 32'h1313);
        setp(1, 0, 1'b1, 4'd13, 8'h03, 1'b1, 1'b1);
        #1 chk("oor pre", bus(1, 0), 32'h3);
        tick();
        scan();

        // randomized traffic, one async reset pulse mid-run
        for (int it = 0; it < 400; it++) begin
            logic [3:0] shared;
            logic       collide;
            shared  = 4'($urandom_range(0, 15));
            collide = ($urandom_range(0, 3) == 0);
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < NP[d]; p++)
                    setp(d, p, 1'($urandom_range(0, 1)),
                         collide ? shared : 4'($urandom_range(0, 15)),
                         8'($urandom), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 2) == 0));
                t_ld[d]    = ($urandom_range(0, 3) == 0);
                t_selin[d] = collide ? shared : 4'($urandom_range(0, 15));
                t_in[d]    = $urandom;
            end
            if (it == 200) begin
                #2 rst_n = 1'b0;
                model_clear();
                #1 check_all("rand reset");
                rst_n = 1'b1;
            end
            tick();
        end
        scan();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
